// File: rtl/tour_distance_if.sv
// Bus between the city stream source / distance ROM and tour_distance.
// The master side feeds cities and ROM data; the slave side is the accumulator.
interface tour_distance_if #(
    parameter int CITY_W = 8,
    parameter int DIST_W = 16,
    parameter int SUM_W  = 24
);
    logic              start;
    logic [CITY_W-1:0] city_in;
    logic              dist_req;
    logic [CITY_W-1:0] dist_addr_a;
    logic [CITY_W-1:0] dist_addr_b;
    logic [DIST_W-1:0] dist_data;
    logic              busy;
    logic [SUM_W-1:0]  total;
    logic              total_valid;
    logic              overflow;

    modport master (
        output start, city_in, dist_data,
        input  dist_req, dist_addr_a, dist_addr_b, busy, total, total_valid, overflow
    );

    modport slave (
        input  start, city_in, dist_data,
        output dist_req, dist_addr_a, dist_addr_b, busy, total, total_valid, overflow
    );
endinterface

// File: rtl/tour_distance.sv
// Sums the edge lengths of one streamed tour (closing edge included) via an
// external 1-cycle distance ROM, saturating at SUM_W bits.
module tour_distance #(
    parameter int CITY_NUM = 30,
    parameter int CITY_W   = 8,
    parameter int DIST_W   = 16,
    parameter int SUM_W    = 24
) (
    input  logic           clk,
    input  logic           reset,
    tour_distance_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STREAM, CLOSE, DRAIN, DONE} state_t;

    localparam int CNT_W = $clog2(CITY_NUM) + 1;
    localparam int EXT_W = ((SUM_W > DIST_W) ? SUM_W : DIST_W) + 1;
    localparam logic [EXT_W-1:0] SUM_MAX = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CITY_NUM - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [CITY_W-1:0] first_city;
    logic [CITY_W-1:0] prev_city;
    logic [SUM_W-1:0]  acc;
    logic              req_r;
    logic              req_d;
    logic              busy_r;
    logic [SUM_W-1:0]  total_r;
    logic              total_valid_r;
    logic              overflow_r;

    logic [EXT_W-1:0]  sum_ext;
    logic              sat;
    logic [SUM_W-1:0]  acc_next;

    always_comb begin
        sum_ext  = EXT_W'(acc) + EXT_W'(bus.dist_data);
        sat      = sum_ext > SUM_MAX;
        acc_next = acc;
        if (req_d) begin
            acc_next = sat ? '1 : sum_ext[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            first_city    <= '0;
            prev_city     <= '0;
            acc           <= '0;
            req_r         <= 1'b0;
            req_d         <= 1'b0;
            busy_r        <= 1'b0;
            total_r       <= '0;
            total_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            req_d         <= req_r;
            total_valid_r <= 1'b0;
            acc           <= acc_next;
            if (req_d && sat) begin
                overflow_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= STREAM;
                        first_city <= bus.city_in;
                        prev_city  <= bus.city_in;
                        count      <= CNT_W'(1);
                        acc        <= '0;
                        overflow_r <= 1'b0;
                        busy_r     <= 1'b1;
                        req_r      <= 1'b1;
                    end
                end
                STREAM: begin
                    prev_city <= bus.city_in;
                    count     <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state <= CLOSE;
                    end
                end
                CLOSE: begin
                    req_r <= 1'b0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    // the closing edge returns this cycle, so commit the post-add value
                    total_r       <= acc_next;
                    total_valid_r <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Destination follows city_in directly so the edge (k-1,k) is requested in cycle k.
    always_comb begin
        bus.dist_addr_b = '0;
        if (state == STREAM) begin
            bus.dist_addr_b = bus.city_in;
        end else if (state == CLOSE) begin
            bus.dist_addr_b = first_city;
        end
    end

    assign bus.dist_req    = req_r;
    assign bus.dist_addr_a = req_r ? prev_city : '0;
    assign bus.busy        = busy_r;
    assign bus.total       = total_r;
    assign bus.total_valid = total_valid_r;
    assign bus.overflow    = overflow_r;
endmodule
